eth_tx_arbiter: RTL and testbench
=================================

Name: eth_tx_arbiter

Overview:
- Shares the single RMII transmit engine (eth_tx) between NUM_REQ packet sources, e.g. an ARP responder and a UDP sender.
- Arbitrates round-robin and latches the winner's full Ethernet frame: 48-bit dst MAC, 48-bit src MAC, 16-bit ether type, 368-bit payload.
- Drives eth_tx's transmit/eth_packet inputs and enforces the 96-bit-time inter-frame gap between frames.
- Sits between the protocol blocks and eth_tx, all in the eth_clk (50 MHz) domain.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
PKT_W, 480, width of one flattened frame (dst, src, type, payload; MSB = dst MAC bit 47)
IFG_CYCLES, 48, idle eth_clk cycles between frames (96 bit times at 2 bits/clk)
START_TIMEOUT, 64, cycles to wait for tx_busy to rise after transmit asserts

Ports:
eth_clk  input  1  50 MHz RMII reference clock
rst_in  input  1  reset, asynchronous, active-high
req  input  NUM_REQ  per-requester frame request, level
pkt_in  input  NUM_REQ*PKT_W  frames; requester i occupies bits [i*PKT_W +: PKT_W]
grant  output  NUM_REQ  one-hot, one-cycle pulse: frame i captured
done  output  NUM_REQ  one-hot, one-cycle pulse: frame i finished on wire, or aborted
tx_err  output  1  one-cycle pulse, coincident with done, on start timeout
tx_busy  input  1  from eth_tx; high while the frame is on the wire
transmit  output  1  to eth_tx start request
eth_packet  output  PKT_W  to eth_tx; latched frame
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous assert, released on the eth_clk edge): state=IDLE, grant=0, done=0, tx_err=0, transmit=0, eth_packet=0, rr_ptr=0, gap counter=0.
- Reset mid-frame aborts silently. No done is issued. eth_tx is reset by the same rst_in.
- FSM states: IDLE, LAUNCH, SEND, GAP.
- IDLE, when any req is high and tx_busy=0:
  - Select the winner: the first set req at index rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - On that edge: latch pkt_in slice into eth_packet, pulse grant[winner], set rr_ptr=(winner+1) mod NUM_REQ, go to LAUNCH.
- Grant latency: 1 cycle from req sampled high to the grant pulse.
- Requester handshake:
  - The requester may change pkt_in or drop req from the cycle after grant.
  - A req still high after grant is a new request. It is considered again only when the FSM returns to IDLE.
- LAUNCH:
  - transmit=1 (level) for every cycle in LAUNCH.
  - On tx_busy=1 → SEND, with transmit=0 on that edge.
  - If START_TIMEOUT cycles elapse without tx_busy → pulse done[winner] and tx_err, then go to GAP.
- SEND:
  - transmit=0; eth_packet held stable.
  - On tx_busy falling (sampled 0) → pulse done[winner], go to GAP.
- GAP:
  - Count IFG_CYCLES cycles, then go to IDLE.
  - Requests arriving during GAP wait. The earliest grant is the cycle after the gap completes.
- Back-to-back frames: at least IFG_CYCLES+1 cycles between the done pulse and the next grant.
- Simultaneous req from all requesters: served strictly in rotation, so no requester waits more than NUM_REQ−1 frames.
- If tx_busy is already high in IDLE (foreign activity): no grant until it falls.
- eth_packet changes only on a grant edge.
- grant, done and tx_err are never asserted together for different indices. At most one bit of grant|done is high per cycle.

Test Plan:
- Reset then single request:
  - Stimulus: req=2'b01, pkt0 = 48'h106530703d6d / 48'h123456789abc / ARP / 368'h0001…; a tx_busy model goes high 2 cycles after transmit and stays high for 1000 cycles.
  - Required: grant=01 one cycle after req; eth_packet equals pkt0; transmit high exactly 2 cycles; done=01 one cycle after tx_busy falls.
- Both req high continuously:
  - Required: grants alternate 01,10,01,10.
  - Required: each grant at least 49 cycles after the previous done; eth_packet matches the granted slice.
- Round-robin pointer after grant to requester 1:
  - Stimulus: req=11 re-asserted.
  - Required: requester 0 is granted next.
- Start timeout:
  - Stimulus: tx_busy held 0.
  - Required: transmit high for exactly 64 cycles; then done and tx_err pulse together; then 48-cycle gap; then IDLE.
- Request during GAP:
  - Stimulus: req0 asserted 10 cycles into GAP.
  - Required: grant exactly 1 cycle after GAP ends, not before.
- Asynchronous reset mid-SEND:
  - Stimulus: rst_in pulsed between clock edges.
  - Required: transmit, busy and eth_packet go to 0 immediately, with no clock edge needed; no done pulse is issued.

Source files
------------

// File: rtl/eth_tx_arbiter.sv
// Round-robin arbiter that shares one RMII transmit engine between several frame sources.
// Captures the winning frame, launches it on eth_tx and enforces the inter-frame gap.
module eth_tx_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int PKT_W         = 480,
  parameter int IFG_CYCLES    = 48,
  parameter int START_TIMEOUT = 64
) (
  input  logic                     eth_clk,
  input  logic                     rst_in,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*PKT_W-1:0] pkt_in,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     tx_err,
  input  logic                     tx_busy,
  output logic                     transmit,
  output logic [PKT_W-1:0]         eth_packet,
  output logic                     busy
);

  localparam int IW   = $clog2(NUM_REQ);
  localparam int IW1  = IW + 1;
  localparam int CMAX = (START_TIMEOUT > IFG_CYCLES) ? START_TIMEOUT : IFG_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_SEND,
    S_GAP
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_rrPtr;
  logic [IW-1:0]   r_winner;
  logic [CW-1:0]   r_cnt;

  logic            w_found;
  logic [IW-1:0]   w_winner;
  logic [IW-1:0]   w_nextPtr;
  logic [IW:0]     w_sum;

  // Scan requesters starting at the round-robin pointer, wrapping modulo NUM_REQ.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_rrPtr} + IW1'(k);
      if (w_sum >= IW1'(NUM_REQ)) begin
        w_sum = w_sum - IW1'(NUM_REQ);
      end
      if (!w_found && req[w_sum[IW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_sum[IW-1:0];
      end
    end
  end

  assign w_nextPtr = (w_winner == IW'(NUM_REQ - 1)) ? '0 : w_winner + IW'(1);
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge eth_clk or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      r_rrPtr    <= '0;
      r_winner   <= '0;
      r_cnt      <= '0;
      grant      <= '0;
      done       <= '0;
      tx_err     <= 1'b0;
      transmit   <= 1'b0;
      eth_packet <= '0;
    end else begin
      grant  <= '0;
      done   <= '0;
      tx_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A busy engine here means foreign traffic; hold off until it clears.
          if (w_found && !tx_busy) begin
            eth_packet <= pkt_in[int'(w_winner)*PKT_W +: PKT_W];
            grant      <= NUM_REQ'(1) << w_winner;
            r_winner   <= w_winner;
            r_rrPtr    <= w_nextPtr;
            transmit   <= 1'b1;
            r_cnt      <= '0;
            r_state    <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (tx_busy) begin
            transmit <= 1'b0;
            r_state  <= S_SEND;
          end else if (r_cnt == CW'(START_TIMEOUT - 1)) begin
            transmit <= 1'b0;
            done     <= NUM_REQ'(1) << r_winner;
            tx_err   <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_GAP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_SEND: begin
          if (!tx_busy) begin
            done    <= NUM_REQ'(1) << r_winner;
            r_cnt   <= '0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_cnt == CW'(IFG_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: round-robin order, launch/timeout timing,
// inter-frame gap and asynchronous reset, with hand-computed expectations.
module tb_eth_tx_arbiter;

  localparam int NUM_REQ       = 2;
  localparam int PKT_W         = 480;
  localparam int IFG_CYCLES    = 48;
  localparam int START_TIMEOUT = 64;

  logic                     eth_clk = 1'b0;
  logic                     rst_in;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*PKT_W-1:0] pkt_in;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic                     tx_err;
  logic                     tx_busy;
  logic                     transmit;
  logic [PKT_W-1:0]         eth_packet;
  logic                     busy;

  logic [PKT_W-1:0] pkt0;
  logic [PKT_W-1:0] pkt1;

  int compared   = 0;
  int mismatched = 0;

  always #5 eth_clk = ~eth_clk;

  eth_tx_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .PKT_W         (PKT_W),
    .IFG_CYCLES    (IFG_CYCLES),
    .START_TIMEOUT (START_TIMEOUT)
  ) dut (
    .eth_clk    (eth_clk),
    .rst_in     (rst_in),
    .req        (req),
    .pkt_in     (pkt_in),
    .grant      (grant),
    .done       (done),
    .tx_err     (tx_err),
    .tx_busy    (tx_busy),
    .transmit   (transmit),
    .eth_packet (eth_packet),
    .busy       (busy)
  );

  task automatic checkOutput(input string tag, input logic [PKT_W-1:0] observed,
                             input logic [PKT_W-1:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Waits for a grant, then plays eth_tx: busy rises after two transmit cycles,
  // stays high busyLen cycles, and the done pulse is expected right after it falls.
  task automatic applyStimulus(input string tag, input logic [1:0] expGrant, input int expGap,
                               input int busyLen, input logic [1:0] nextReq);
    int n = 0;
    int txHigh = 0;
    logic [PKT_W-1:0] expPkt;
    expPkt = expGrant[1] ? pkt1 : pkt0;
    while (grant == 2'b00 && n < 300) begin
      @(negedge eth_clk);
      n++;
    end
    checkOutput({tag, "_latency"}, PKT_W'(n), PKT_W'(expGap));
    checkOutput({tag, "_grant"}, PKT_W'(grant), PKT_W'(expGrant));
    checkOutput({tag, "_packet"}, eth_packet, expPkt);
    req = nextReq;
    while (transmit && txHigh < 200) begin
      txHigh++;
      if (txHigh == 2) tx_busy = 1'b1;
      @(negedge eth_clk);
    end
    checkOutput({tag, "_transmit_cycles"}, PKT_W'(txHigh), PKT_W'(2));
    repeat (busyLen) @(negedge eth_clk);
    checkOutput({tag, "_held_packet"}, eth_packet, expPkt);
    checkOutput({tag, "_no_early_done"}, PKT_W'(done), PKT_W'(0));
    tx_busy = 1'b0;
    @(negedge eth_clk);
    checkOutput({tag, "_done"}, PKT_W'(done), PKT_W'(expGrant));
    checkOutput({tag, "_tx_err"}, PKT_W'(tx_err), PKT_W'(0));
  endtask

  initial begin
    int n;
    int idleAt;
    int txHigh;
    logic [1:0] doneSeen;
    logic [1:0] grantSeen;

    pkt0 = {48'h106530703d6d, 48'h123456789abc, 16'h0806, 368'h0001_0800_0604_0001_1234_5678};
    pkt1 = {48'hffffffffffff, 48'h02aabbccddee, 16'h0800, 368'h4500_001c_dead_beef_cafe_f00d};
    pkt_in  = {pkt1, pkt0};
    rst_in  = 1'b1;
    req     = 2'b00;
    tx_busy = 1'b0;

    repeat (2) @(negedge eth_clk);
    checkOutput("rst_grant", PKT_W'(grant), PKT_W'(0));
    checkOutput("rst_done", PKT_W'(done), PKT_W'(0));
    checkOutput("rst_tx_err", PKT_W'(tx_err), PKT_W'(0));
    checkOutput("rst_transmit", PKT_W'(transmit), PKT_W'(0));
    checkOutput("rst_packet", eth_packet, PKT_W'(0));
    checkOutput("rst_busy", PKT_W'(busy), PKT_W'(0));
    rst_in = 1'b0;
    @(negedge eth_clk);

    req = 2'b01;
    applyStimulus("single", 2'b01, 1, 1000, 2'b11);

    // Pointer sits at 1 after the first frame, so the rotation starts with requester 1.
    applyStimulus("rr_a", 2'b10, IFG_CYCLES + 1, 20, 2'b11);
    applyStimulus("rr_b", 2'b01, IFG_CYCLES + 1, 20, 2'b11);
    applyStimulus("rr_c", 2'b10, IFG_CYCLES + 1, 20, 2'b11);
    applyStimulus("rr_d", 2'b01, IFG_CYCLES + 1, 20, 2'b10);
    applyStimulus("ptr_a", 2'b10, IFG_CYCLES + 1, 20, 2'b11);
    applyStimulus("ptr_b", 2'b01, IFG_CYCLES + 1, 20, 2'b00);

    // Start timeout: tx_busy never rises.
    req = 2'b01;
    n = 0;
    while (grant == 2'b00 && n < 300) begin
      @(negedge eth_clk);
      n++;
    end
    checkOutput("to_latency", PKT_W'(n), PKT_W'(IFG_CYCLES + 1));
    checkOutput("to_grant", PKT_W'(grant), PKT_W'(2'b01));
    req = 2'b00;
    txHigh = 0;
    while (transmit && txHigh < 300) begin
      txHigh++;
      @(negedge eth_clk);
    end
    checkOutput("to_transmit_cycles", PKT_W'(txHigh), PKT_W'(START_TIMEOUT));
    checkOutput("to_done", PKT_W'(done), PKT_W'(2'b01));
    checkOutput("to_tx_err", PKT_W'(tx_err), PKT_W'(1));

    // Request raised ten cycles into the gap must wait for the gap to finish.
    idleAt = -1;
    n = 0;
    while (n < 200) begin
      @(negedge eth_clk);
      n++;
      if (n == 10) req = 2'b01;
      if (!busy && idleAt < 0) idleAt = n;
      if (grant != 2'b00) break;
    end
    checkOutput("gap_idle_at", PKT_W'(idleAt), PKT_W'(IFG_CYCLES));
    checkOutput("gap_grant_at", PKT_W'(n), PKT_W'(IFG_CYCLES + 1));
    checkOutput("gap_grant", PKT_W'(grant), PKT_W'(2'b01));
    req = 2'b00;

    // Bring the frame into SEND, then reset between clock edges.
    txHigh = 0;
    while (transmit && txHigh < 200) begin
      txHigh++;
      if (txHigh == 2) tx_busy = 1'b1;
      @(negedge eth_clk);
    end
    repeat (5) @(negedge eth_clk);
    checkOutput("send_busy", PKT_W'(busy), PKT_W'(1));
    #2;
    rst_in = 1'b1;
    #1;
    checkOutput("arst_transmit", PKT_W'(transmit), PKT_W'(0));
    checkOutput("arst_busy", PKT_W'(busy), PKT_W'(0));
    checkOutput("arst_packet", eth_packet, PKT_W'(0));
    tx_busy = 1'b0;
    @(negedge eth_clk);
    rst_in = 1'b0;
    doneSeen = 2'b00;
    repeat (10) begin
      @(negedge eth_clk);
      doneSeen = doneSeen | done;
    end
    checkOutput("arst_no_done", PKT_W'(doneSeen), PKT_W'(0));

    // Foreign traffic on the engine blocks grants; pointer restarts at 0 after reset.
    tx_busy = 1'b1;
    req = 2'b11;
    grantSeen = 2'b00;
    repeat (5) begin
      @(negedge eth_clk);
      grantSeen = grantSeen | grant;
    end
    checkOutput("foreign_no_grant", PKT_W'(grantSeen), PKT_W'(0));
    tx_busy = 1'b0;
    applyStimulus("post_reset", 2'b01, 1, 20, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
